// File: rtl/spi_slave_sync.sv
// SPI responder oversampled on clk: synchronised SCK/SS/MOSI, CPOL/CPHA modes 0-3,
// full-duplex MSB-first words through a one-deep TX holding buffer.
module spi_slave_sync #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MODE,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              tx_underrun
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam int                FILL_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic                   sck_hist_q, sck_hist_d, ss_hist_q, ss_hist_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   arm_q, arm_d;
  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [DATA_W-1:0]      tx_buf_q, tx_buf_d;
  logic                   tx_full_q, tx_full_d, underrun_q, underrun_d;
  logic                   rx_valid_q, rx_valid_d, frame_done_q, frame_done_d;
  logic                   busy_q, busy_d, oe_q, oe_d, miso_q, miso_d;

  logic sck_s, ss_s, mosi_s, sck_rise, sck_fall, ss_fall, ss_rise, lead, trail;
  logic do_load, do_shift, do_sample;
  logic [DATA_W-1:0] rx_word;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sck_hist_d  = sck_s;
    ss_hist_d   = ss_s;
    sck_rise    = sck_s & ~sck_hist_q;
    sck_fall    = ~sck_s & sck_hist_q;
    ss_fall     = ~ss_s & ss_hist_q;
    ss_rise     = ss_s & ~ss_hist_q;
    lead        = mode_q[1] ? sck_fall : sck_rise;
    trail       = mode_q[1] ? sck_rise : sck_fall;
    rx_word     = {rx_shift_q[DATA_W-2:0], mosi_s};

    // After reset, a new frame needs SS seen high through a chain refilled with real samples.
    fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    arm_d  = arm_q | ((fill_q == FILL_MAX) & ss_s);

    state_d      = state_q;
    mode_d       = mode_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    tx_buf_d     = tx_buf_q;
    tx_full_d    = tx_full_q;
    underrun_d   = underrun_q;
    rx_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    oe_d         = oe_q;
    do_load      = 1'b0;
    do_shift     = 1'b0;
    do_sample    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall && arm_q) begin
          state_d   = ACTIVE;
          mode_d    = MODE;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          oe_d      = 1'b1;
          do_load   = ~MODE[0];
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else if (!mode_q[0]) begin
          do_sample = lead;
          do_load   = trail && (bit_cnt_q == '0);
          do_shift  = trail && (bit_cnt_q != '0);
        end else begin
          do_sample = trail;
          do_load   = lead && (bit_cnt_q == '0);
          do_shift  = lead && (bit_cnt_q != '0);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        oe_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (do_sample) begin
      rx_shift_d = rx_word;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d  = '0;
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    if (do_load) begin
      if (tx_full_q) begin
        shift_d   = tx_buf_q;
        tx_full_d = 1'b0;
      end else begin
        shift_d    = IDLE_WORD;
        underrun_d = 1'b1;
      end
    end else if (do_shift) begin
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
    end

    // A write is judged against the buffer state before any same-cycle load.
    if (tx_wr && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    miso_d = (state_d == ACTIVE) ? shift_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q   <= {SYNC_STAGES{MODE[1]}};
      sck_hist_q   <= MODE[1];
      ss_sync_q    <= '1;
      ss_hist_q    <= 1'b1;
      mosi_sync_q  <= '0;
      fill_q       <= '0;
      arm_q        <= 1'b0;
      state_q      <= IDLE;
      mode_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      tx_buf_q     <= '0;
      tx_full_q    <= 1'b0;
      underrun_q   <= 1'b0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      oe_q         <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      sck_hist_q   <= sck_hist_d;
      ss_sync_q    <= ss_sync_d;
      ss_hist_q    <= ss_hist_d;
      mosi_sync_q  <= mosi_sync_d;
      fill_q       <= fill_d;
      arm_q        <= arm_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      tx_buf_q     <= tx_buf_d;
      tx_full_q    <= tx_full_d;
      underrun_q   <= underrun_d;
      rx_valid_q   <= rx_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      oe_q         <= oe_d;
      miso_q       <= miso_d;
    end
  end

  assign MISO        = miso_q;
  assign miso_oe     = oe_q;
  assign tx_ready    = ~tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign tx_underrun = underrun_q;

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Clock-domain-synchronous SPI responder: the far end of the four-chip-select SPI master bus.
- Oversamples SCK, SS and MOSI with the system clock and supports all four CPOL/CPHA modes.
- Shifts full-duplex bytes MSB first, with a one-deep TX holding buffer and an RX valid strobe.
- Replaces the free-running, SCK-clocked slave models with a block that the system-side logic (packet/UART path) can use directly.

Parameters:
- DATA_W, 8, bits per SPI word.
- SYNC_STAGES, 2, flip-flop stages on SCK, SS and MOSI before edge detection (minimum 2).
- IDLE_WORD, 8'hFF, word shifted out when the TX buffer is empty at a word boundary.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- MODE  in  2  [1]=CPOL, [0]=CPHA; sampled when SS asserts.
- SCK  in  1  SPI clock from master (asynchronous).
- SS  in  1  chip select, active low (asynchronous).
- MOSI  in  1  master-out data (asynchronous).
- MISO  out  1  slave-out data.
- miso_oe  out  1  high while the frame is active; the top level uses it to tri-state/mux the shared MISO.
- tx_data  in  DATA_W  word to transmit.
- tx_wr  in  1  one-cycle write strobe for tx_data.
- tx_ready  out  1  TX holding buffer empty.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  frame active (synchronised SS low).
- frame_done  out  1  one-cycle pulse on SS deassertion.
- tx_underrun  out  1  sticky; IDLE_WORD was sent; cleared by rst only.

Behaviour:
- Reset (rst=1 at clk rising edge) sets all of the following: MISO=0, miso_oe=0, busy=0, rx_valid=0, frame_done=0, tx_underrun=0, rx_data=0, tx_ready=1, bit counter 0, FSM=IDLE, synchroniser stages loaded to SCK=CPOL idle of MODE, SS=1.
- Reset mid-frame aborts immediately. The master's remaining bits are ignored until SS is seen high and then low again.
- Synchronisers: SYNC_STAGES flops, plus one history flop on SCK and SS. Edge detect is a comparison of the last two stages. Input-to-action latency is SYNC_STAGES+1 clk cycles.
- Timing requirement: SCK high and low phases are each ≥ 3 clk periods. SS setup to first SCK edge is ≥ 3 clk periods.
- Leading edge = SCK leaving the CPOL level. Trailing edge = SCK returning to it.
- FSM IDLE -> ACTIVE on synchronised SS falling edge:
  - latch MODE into mode_q;
  - bit_cnt=0, busy=1, miso_oe=1.
- CPHA=0:
  - On SS fall: load shift register from the TX buffer (or IDLE_WORD) and drive MSB on MISO.
  - Sample synchronised MOSI on the leading edge; shift out on the trailing edge.
  - After the DATA_W-th sample, the trailing edge loads the next word instead of shifting.
- CPHA=1:
  - On the leading edge with bit_cnt=0: load the next word and drive its MSB.
  - On other leading edges: shift.
  - Sample on the trailing edge.
- Word completion: on the DATA_W-th sample, rx_data <= assembled word, rx_valid=1 for exactly one cycle, bit_cnt wraps to 0. Back-to-back words within one frame are supported without gaps.
- TX buffer behaviour:
  - tx_wr while tx_ready=1: store tx_data, tx_ready=0.
  - tx_wr while tx_ready=0: ignored; the buffer is unchanged.
  - On a load, the buffer moves to the shift register and tx_ready=1.
  - If the buffer is empty at a load, shift in IDLE_WORD and set tx_underrun.
  - tx_wr in the same cycle as a load with the buffer empty: the load takes IDLE_WORD, and the written data is stored in the buffer for the next word.
- ACTIVE -> IDLE on synchronised SS rising edge:
  - frame_done=1 for one cycle; busy=0 and miso_oe=0 on the following cycle; MISO=0.
  - A partial word (bit_cnt≠0) is discarded: no rx_valid, rx_data unchanged.
  - TX buffer contents and the consumed shift data are not restored.
- MODE changes while ACTIVE are ignored until the next frame.
- SCK edges while IDLE are ignored.

Test Plan:
- Mode 0, tx_wr 8'hA5 before frame, master sends 8'h3C -> master receives 8'hA5; rx_valid pulses once with rx_data=8'h3C; frame_done one pulse after SS rises; tx_ready=1.
- Modes 1, 2, 3, each with tx 8'hF1 and master 8'h96 -> each exchange is bit-exact; the master configured in the same mode reads 8'hF1.
- Two-word frame, mode 0: write 8'h11, write 8'h22 after the first load -> master reads 8'h11, 8'h22; two rx_valid pulses; tx_underrun=0.
- Empty buffer, two-word frame, second write omitted -> second word out is 8'hFF; tx_underrun=1 and stays 1 after the frame.
- SS deasserted after 5 bits of 8'hC3 -> no rx_valid; rx_data holds the previous value; busy falls; the next full frame receives correctly.
- rst asserted mid-word, then a fresh frame with tx 8'h5A -> all outputs at reset values the next cycle; the fresh frame exchanges 8'h5A correctly.
